board_row_fetch: RTL and testbench
==================================

// Module: board_row_fetch
// PURPOSE
//  Upstream feeder for color_mapper. On each row request (LD_Row/rowNum) it reads one
//  10-cell row from the board RAM, overlays the falling piece, and presents the row on
//  Row[] with a one-cycle rowReady pulse. The output row is double-buffered, so
//  color_mapper never sees a partially written row while it scans the current one.
// PARAMETERS
//  BOARD_W  10  cells per row
//  BOARD_H  20  rows on the board
//  CELL_W   16  bits per cell ([11:8] R, [7:4] G, [3:0] B; zero means empty)
//  ADDR_W    8  board RAM address width; address = row*BOARD_W + col
//  RD_LAT    1  board RAM read latency in clocks (1..3)
// PORTS
//  Clk          in   1              system clock; every register updates on the rising edge
//  reset_n      in   1              synchronous reset, active-low
//  LD_Row       in   1              row request from color_mapper; a level that may stay high for many cycles
//  rowNum       in   8              requested row index
//  piece_valid  in   1              a falling piece is on the board
//  piece_x      in   4 x4           column of each of the 4 piece blocks
//  piece_y      in   5 x4           row of each of the 4 piece blocks
//  piece_color  in   CELL_W         color of the falling piece
//  mem_rd       out  1              board RAM read strobe
//  mem_addr     out  ADDR_W         board RAM read address
//  mem_data     in   CELL_W         board RAM read data, valid RD_LAT clocks after mem_rd
//  Row          out  CELL_W x BOARD_W  front row buffer, read by color_mapper
//  rowReady     out  1              one-cycle pulse: Row has just been updated
//  busy         out  1              a fetch is in progress
// BEHAVIOUR
//  Reset (reset_n=0 at an edge): Row all 0, rowReady=0, busy=0, mem_rd=0, mem_addr=0,
//   pending flag cleared, edge-detect register=0, state=IDLE. Asserting reset mid-fetch
//   abandons the fetch. The front buffer is not updated from that fetch.
//  Request: a request is the rising edge of LD_Row (LD_Row=1 and the registered previous
//   LD_Row=0). Holding LD_Row high produces one request only.
//  In IDLE, a request is accepted at that edge. The unit then latches rowNum and all
//   piece_* inputs, and goes to ISSUE. The latched piece_* values are used for the whole row.
//  Request while busy: the unit stores rowNum in a one-deep pending slot. A newer request
//   overwrites the slot. On exit from COMMIT, a pending request is accepted exactly as
//   if it came from IDLE, with no extra idle cycle.
//  FSM states and transitions:
//   IDLE   -> ISSUE   on an accepted request
//   ISSUE  -> DRAIN   after BOARD_W cycles; in cycle c (0..9): mem_rd=1,
//                     mem_addr = row*BOARD_W + c
//   DRAIN  -> COMMIT  after RD_LAT cycles; captures the outstanding data
//   COMMIT -> IDLE    or -> ISSUE if a request is pending; lasts 1 cycle
//  Outputs per state:
//   busy=1 in ISSUE, DRAIN and COMMIT. mem_rd=0 outside ISSUE.
//   rowReady=1 only in COMMIT.
//  Capture: the word read for col c is captured into back buffer[c] RD_LAT cycles after
//   its issue cycle.
//  Overlay: if piece_valid is latched high and any block k has piece_y[k]==row and
//   piece_x[k]==c, the unit stores the latched piece_color instead of mem_data.
//  Commit: back buffer -> Row, all cells at once, at the edge that enters COMMIT.
//   Row changes only at this edge.
//  Latency: rowReady is high in the cycle that starts BOARD_W+RD_LAT edges after the
//   accept edge (11 edges for RD_LAT=1).
//  Out-of-range rows (rowNum >= BOARD_H, e.g. 20 at the frame bottom):
//   - no RAM reads: mem_rd stays 0 through ISSUE;
//   - the back buffer is filled with 0 and the overlay is suppressed;
//   - the timing is identical to an in-range row.
//  Arithmetic: row*BOARD_W is computed at ADDR_W bits and cannot overflow for in-range
//   rows (max 199). Piece blocks with coordinates outside the board never match.
// TESTING
//  1. Row fetch: reset, load RAM cell(r,c)=16'h0100*r+c, pulse LD_Row with rowNum=3,
//     RD_LAT=1 -> mem_addr steps 30..39. rowReady pulses once, 11 edges after accept.
//     Row[c]=16'h0300+c.
//  2. Piece overlay: piece_valid=1, blocks at (x,y)=(4,3),(5,3),(4,4),(5,4),
//     piece_color=16'h0F00, fetch row 3 -> Row[4]=Row[5]=16'h0F00. All other cells come
//     from RAM.
//  3. Request while busy: hold LD_Row high for 30 cycles -> exactly one fetch.
//     Then make requests for rows 5 and 7 while busy -> the pending slot holds 7.
//     Row 7 is fetched straight after COMMIT, with no idle cycle.
//  4. Out-of-range row: rowNum=20 -> mem_rd never asserted, Row all 0, rowReady at the
//     normal latency.
//  5. Mid-fetch reset: set reset_n=0 in ISSUE cycle 4 -> next cycle busy=0, rowReady=0,
//     Row all 0. No rowReady pulse follows.
//  6. RD_LAT=3 build: repeat test 1 -> same Row contents, rowReady 13 edges after accept.

Source files
------------

// File: rtl/board_row_fetch.sv
// Fetches one board row from RAM, overlays the falling piece and publishes it
// through a double-buffered row register with a one-cycle rowReady pulse.
module board_row_fetch #(
  parameter int BOARD_W = 10,
  parameter int BOARD_H = 20,
  parameter int CELL_W  = 16,
  parameter int ADDR_W  = 8,
  parameter int RD_LAT  = 1
) (
  input  logic                      Clk,
  input  logic                      reset_n,
  input  logic                      LD_Row,
  input  logic [7:0]                rowNum,
  input  logic                      piece_valid,
  input  logic [15:0]               piece_x,
  input  logic [19:0]               piece_y,
  input  logic [CELL_W-1:0]         piece_color,
  output logic                      mem_rd,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [CELL_W-1:0]         mem_data,
  output logic [CELL_W*BOARD_W-1:0] Row,
  output logic                      rowReady,
  output logic                      busy
);

  localparam int COL_W = $clog2(BOARD_W);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, COMMIT} state_t;

  state_t              state_q;
  logic                ldPrev_q;
  logic                pendValid_q;
  logic [7:0]          pendRow_q;
  logic [7:0]          rowIdx_q;
  logic                oor_q;
  logic                pieceValid_q;
  logic [15:0]         pieceX_q;
  logic [19:0]         pieceY_q;
  logic [CELL_W-1:0]   pieceColor_q;
  logic [COL_W-1:0]    issueCnt_q;
  logic [1:0]          drainCnt_q;
  logic                memRd_q;
  logic [ADDR_W-1:0]   memAddr_q;
  logic                rowReady_q;
  logic                busy_q;
  logic                pipeValid_q [RD_LAT];
  logic [COL_W-1:0]    pipeCol_q   [RD_LAT];
  logic [CELL_W-1:0]   back_q      [BOARD_W];
  logic [CELL_W-1:0]   back_d      [BOARD_W];
  logic [CELL_W-1:0]   front_q     [BOARD_W];

  logic                req;
  logic                startFetch;
  logic [7:0]          startRow;
  logic                startOor;
  logic [ADDR_W-1:0]   startAddr;
  logic                capEn;
  logic [COL_W-1:0]    capCol;
  logic                overlayHit;
  logic [CELL_W-1:0]   capWord;

  // A fresh request in COMMIT wins over the pending slot since it is newer.
  assign req        = LD_Row && !ldPrev_q;
  assign startFetch = ((state_q == IDLE) && req) ||
                      ((state_q == COMMIT) && (req || pendValid_q));
  assign startRow   = ((state_q == COMMIT) && !req) ? pendRow_q : rowNum;
  assign startOor   = (startRow >= 8'(BOARD_H));
  assign startAddr  = ADDR_W'(32'(startRow) * BOARD_W);

  assign capEn  = pipeValid_q[RD_LAT-1];
  assign capCol = pipeCol_q[RD_LAT-1];

  always_comb begin
    overlayHit = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (pieceValid_q && (pieceX_q[4*k +: 4] == 4'(capCol)) &&
          ({3'b000, pieceY_q[5*k +: 5]} == rowIdx_q)) begin
        overlayHit = 1'b1;
      end
    end
  end

  assign capWord = oor_q ? '0 : (overlayHit ? pieceColor_q : mem_data);

  // The last column lands on the same edge that commits, so commit copies back_d.
  always_comb begin
    for (int c = 0; c < BOARD_W; c++) begin
      back_d[c] = back_q[c];
    end
    if (capEn) begin
      back_d[capCol] = capWord;
    end
  end

  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ldPrev_q     <= 1'b0;
      pendValid_q  <= 1'b0;
      pendRow_q    <= '0;
      rowIdx_q     <= '0;
      oor_q        <= 1'b0;
      pieceValid_q <= 1'b0;
      pieceX_q     <= '0;
      pieceY_q     <= '0;
      pieceColor_q <= '0;
      issueCnt_q   <= '0;
      drainCnt_q   <= '0;
      memRd_q      <= 1'b0;
      memAddr_q    <= '0;
      rowReady_q   <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < RD_LAT; i++) begin
        pipeValid_q[i] <= 1'b0;
        pipeCol_q[i]   <= '0;
      end
      for (int c = 0; c < BOARD_W; c++) begin
        back_q[c]  <= '0;
        front_q[c] <= '0;
      end
    end else begin
      ldPrev_q <= LD_Row;
      for (int c = 0; c < BOARD_W; c++) begin
        back_q[c] <= back_d[c];
      end

      pipeValid_q[0] <= (state_q == ISSUE);
      pipeCol_q[0]   <= issueCnt_q;
      for (int i = 1; i < RD_LAT; i++) begin
        pipeValid_q[i] <= pipeValid_q[i-1];
        pipeCol_q[i]   <= pipeCol_q[i-1];
      end

      if (startFetch) begin
        pendValid_q <= 1'b0;
      end else if (req && (state_q != IDLE)) begin
        pendValid_q <= 1'b1;
        pendRow_q   <= rowNum;
      end

      if (startFetch) begin
        state_q      <= ISSUE;
        rowIdx_q     <= startRow;
        oor_q        <= startOor;
        pieceValid_q <= piece_valid;
        pieceX_q     <= piece_x;
        pieceY_q     <= piece_y;
        pieceColor_q <= piece_color;
        issueCnt_q   <= '0;
        memRd_q      <= !startOor;
        memAddr_q    <= startAddr;
        busy_q       <= 1'b1;
        rowReady_q   <= 1'b0;
      end else begin
        case (state_q)
          ISSUE: begin
            if (issueCnt_q == COL_W'(BOARD_W - 1)) begin
              state_q    <= DRAIN;
              drainCnt_q <= '0;
              memRd_q    <= 1'b0;
            end else begin
              issueCnt_q <= issueCnt_q + 1'b1;
              memAddr_q  <= memAddr_q + 1'b1;
            end
          end
          DRAIN: begin
            if (drainCnt_q == 2'(RD_LAT - 1)) begin
              state_q    <= COMMIT;
              rowReady_q <= 1'b1;
              for (int c = 0; c < BOARD_W; c++) begin
                front_q[c] <= back_d[c];
              end
            end else begin
              drainCnt_q <= drainCnt_q + 1'b1;
            end
          end
          COMMIT: begin
            state_q    <= IDLE;
            rowReady_q <= 1'b0;
            busy_q     <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    Row = '0;
    for (int c = 0; c < BOARD_W; c++) begin
      Row[c*CELL_W +: CELL_W] = front_q[c];
    end
  end

  assign mem_rd   = memRd_q;
  assign mem_addr = memAddr_q;
  assign rowReady = rowReady_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_board_row_fetch.sv
// Directed bench for board_row_fetch: one instance with RD_LAT=1 and one with
// RD_LAT=3 share stimulus, each fed by its own board RAM model.
module tb_board_row_fetch;

  logic         Clk = 1'b0;
  logic         reset_n;
  logic         LD_Row;
  logic [7:0]   rowNum;
  logic         piece_valid;
  logic [15:0]  piece_x;
  logic [19:0]  piece_y;
  logic [15:0]  piece_color;

  logic         memRd1, memRd3;
  logic [7:0]   memAddr1, memAddr3;
  logic [15:0]  memData1, memData3;
  logic [159:0] rowOut1, rowOut3;
  logic         rowReady1, rowReady3;
  logic         busy1, busy3;

  logic [15:0]  ram [256];
  logic [15:0]  rdPipe1 [1];
  logic [15:0]  rdPipe3 [3];

  int checkCount = 0;
  int errorCount = 0;

  always #5 Clk = ~Clk;

  board_row_fetch #(.RD_LAT(1)) dut1 (
    .Clk(Clk), .reset_n(reset_n), .LD_Row(LD_Row), .rowNum(rowNum),
    .piece_valid(piece_valid), .piece_x(piece_x), .piece_y(piece_y),
    .piece_color(piece_color), .mem_rd(memRd1), .mem_addr(memAddr1),
    .mem_data(memData1), .Row(rowOut1), .rowReady(rowReady1), .busy(busy1)
  );

  board_row_fetch #(.RD_LAT(3)) dut3 (
    .Clk(Clk), .reset_n(reset_n), .LD_Row(LD_Row), .rowNum(rowNum),
    .piece_valid(piece_valid), .piece_x(piece_x), .piece_y(piece_y),
    .piece_color(piece_color), .mem_rd(memRd3), .mem_addr(memAddr3),
    .mem_data(memData3), .Row(rowOut3), .rowReady(rowReady3), .busy(busy3)
  );

  // Unread cycles return a poison word so stray captures show up in Row.
  always @(posedge Clk) begin
    rdPipe1[0] <= memRd1 ? ram[memAddr1] : 16'hDEAD;
    rdPipe3[0] <= memRd3 ? ram[memAddr3] : 16'hDEAD;
    rdPipe3[1] <= rdPipe3[0];
    rdPipe3[2] <= rdPipe3[1];
  end
  assign memData1 = rdPipe1[0];
  assign memData3 = rdPipe3[2];

  task automatic checkOutput(input string tag, input logic [159:0] observed,
                             input logic [159:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [159:0] ramRow(input int r);
    logic [159:0] v;
    v = '0;
    for (int c = 0; c < 10; c++) v[c*16 +: 16] = 16'(16'h0100 * r + c);
    return v;
  endfunction

  // Drives a one-cycle LD_Row pulse; returns just after the accept edge.
  task automatic applyStimulus(input logic [7:0] row);
    @(negedge Clk);
    rowNum = row;
    LD_Row = 1'b1;
    @(posedge Clk);
    #1;
    LD_Row = 1'b0;
  endtask

  task automatic fetchRow(input logic [7:0] row, input string tag,
                          input logic [159:0] expRow, input int expReads);
    int readyEdge1, readyEdge3, readyCount, rdCount;
    logic savedValid;
    logic [15:0] savedColor;
    applyStimulus(row);
    savedValid  = piece_valid;
    savedColor  = piece_color;
    piece_valid = 1'b0;
    piece_color = 16'h0AAA;
    readyEdge1 = -1;
    readyEdge3 = -1;
    readyCount = 0;
    rdCount    = 0;
    for (int e = 0; e <= 20; e++) begin
      if (e > 0) begin
        @(posedge Clk);
        #1;
      end
      if (memRd1) begin
        rdCount++;
        checkOutput({tag, "_addr"}, 160'(memAddr1), 160'(row * 10 + e));
      end
      if (rowReady1) begin
        readyCount++;
        if (readyEdge1 < 0) readyEdge1 = e;
      end
      if (rowReady3 && readyEdge3 < 0) readyEdge3 = e;
    end
    piece_valid = savedValid;
    piece_color = savedColor;
    checkOutput({tag, "_latency"},      160'(readyEdge1), 160'(11));
    checkOutput({tag, "_latency_lat3"}, 160'(readyEdge3), 160'(13));
    checkOutput({tag, "_pulses"},       160'(readyCount), 160'(1));
    checkOutput({tag, "_reads"},        160'(rdCount),    160'(expReads));
    checkOutput({tag, "_row"},          rowOut1,          expRow);
    checkOutput({tag, "_row_lat3"},     rowOut3,          expRow);
  endtask

  logic [159:0] expRow;
  int           pulses;
  int           waitCount;

  initial begin
    for (int a = 0; a < 256; a++) begin
      ram[a] = (a < 200) ? 16'(16'h0100 * (a / 10) + (a % 10)) : 16'hBAD0;
    end
    reset_n     = 1'b0;
    LD_Row      = 1'b0;
    rowNum      = '0;
    piece_valid = 1'b0;
    piece_x     = '0;
    piece_y     = '0;
    piece_color = '0;
    repeat (3) @(posedge Clk);
    #1;
    checkOutput("reset_row",   rowOut1,           '0);
    checkOutput("reset_flags", {rowReady1, busy1, memRd1}, '0);
    checkOutput("reset_addr",  160'(memAddr1),    '0);
    @(negedge Clk);
    reset_n = 1'b1;

    fetchRow(8'd3, "t1", ramRow(3), 10);

    piece_valid = 1'b1;
    piece_x     = {4'd5, 4'd4, 4'd5, 4'd4};
    piece_y     = {5'd4, 5'd4, 5'd3, 5'd3};
    piece_color = 16'h0F00;
    expRow = ramRow(3);
    expRow[4*16 +: 16] = 16'h0F00;
    expRow[5*16 +: 16] = 16'h0F00;
    fetchRow(8'd3, "t2_row3", expRow, 10);
    expRow = ramRow(4);
    expRow[4*16 +: 16] = 16'h0F00;
    expRow[5*16 +: 16] = 16'h0F00;
    fetchRow(8'd4, "t2_row4", expRow, 10);
    fetchRow(8'd2, "t2_row2", ramRow(2), 10);
    piece_valid = 1'b0;

    @(negedge Clk);
    rowNum = 8'd2;
    LD_Row = 1'b1;
    pulses = 0;
    repeat (30) begin
      @(posedge Clk);
      #1;
      if (rowReady1) pulses++;
    end
    LD_Row = 1'b0;
    repeat (5) begin
      @(posedge Clk);
      #1;
      if (rowReady1) pulses++;
    end
    checkOutput("t3_hold_pulses", 160'(pulses), 160'(1));

    @(negedge Clk); rowNum = 8'd1; LD_Row = 1'b1;
    @(negedge Clk); LD_Row = 1'b0;
    @(negedge Clk); rowNum = 8'd5; LD_Row = 1'b1;
    @(negedge Clk); LD_Row = 1'b0;
    @(negedge Clk); rowNum = 8'd7; LD_Row = 1'b1;
    @(negedge Clk); LD_Row = 1'b0;
    waitCount = 0;
    while (!rowReady1 && waitCount < 20) begin
      @(posedge Clk);
      #1;
      waitCount++;
    end
    checkOutput("t3_first_ready", 160'(rowReady1), 160'(1));
    checkOutput("t3_first_row",   rowOut1,         ramRow(1));
    @(posedge Clk);
    #1;
    checkOutput("t3_pend_start", {busy1, memRd1, rowReady1}, 3'b110);
    checkOutput("t3_pend_addr",  160'(memAddr1), 160'(70));
    waitCount = 0;
    while (!rowReady1 && waitCount < 20) begin
      @(posedge Clk);
      #1;
      waitCount++;
    end
    checkOutput("t3_pend_latency", 160'(waitCount), 160'(11));
    checkOutput("t3_pend_row",     rowOut1,         ramRow(7));
    @(posedge Clk);
    #1;
    checkOutput("t3_pend_done", 160'(busy1), 160'(0));
    repeat (5) @(posedge Clk);

    applyStimulus(8'd6);
    repeat (4) @(posedge Clk);
    #1;
    checkOutput("t5_issue_addr", 160'(memAddr1), 160'(64));
    reset_n = 1'b0;
    @(posedge Clk);
    #1;
    reset_n = 1'b1;
    checkOutput("t5_flags", {busy1, rowReady1, memRd1}, '0);
    checkOutput("t5_row",   rowOut1, '0);
    pulses = 0;
    repeat (20) begin
      @(posedge Clk);
      #1;
      if (rowReady1 || rowReady3) pulses++;
    end
    checkOutput("t5_no_ready", 160'(pulses), 160'(0));

    fetchRow(8'd9,  "t4_row9",  ramRow(9), 10);
    fetchRow(8'd20, "t4_row20", '0,        0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
